multicycle_ctrl: RTL and testbench

// - Multi-cycle main control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB per instruction.
// - Decodes opcode to datapath controls: branch, alusrc, load, aluops, extnrops, mem, regwrite.
// - Adds OP-IMM support, ready handshakes to instruction and data memory, wait timeout and an illegal-opcode trap.
// - Sits between the fetch unit / IR and the datapath. Uses the same control encodings as the single-cycle control.

---
 rtl/multicycle_ctrl_pkg.sv | 51 +++++
 rtl/multicycle_ctrl_decode.sv | 58 +++++
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl_pkg : shared opcodes, control encodings, states, trap causes
// Revision: 1.0
// ============================================================================
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPCODE_I     = 7'b0000011;
  localparam logic [6:0] OPCODE_S     = 7'b0100011;
  localparam logic [6:0] OPCODE_R     = 7'b0110011;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

  localparam logic [1:0] OPCODE_I_ALU = 2'b00;
  localparam logic [1:0] OPCODE_S_ALU = 2'b00;
  localparam logic [1:0] OPCODE_R_ALU = 2'b10;
  localparam logic [1:0] OPCODE_B_ALU = 2'b01;

  localparam logic [1:0] EXTNR_I = 2'b00;
  localparam logic [1:0] EXTNR_S = 2'b01;
  localparam logic [1:0] EXTNR_B = 2'b10;
  localparam logic [1:0] EXTNR_U = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'b10;
  localparam logic [1:0] CAUSE_DATA_TO  = 2'b11;

  typedef struct packed {
    logic       alusrc;
    logic       load;
    logic [1:0] aluops;
    logic [1:0] extnrops;
    logic       is_mem;
    logic       is_store;
    logic       is_branch;
    logic       legal;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_decode.sv
`default_nettype none
// ============================================================================
// ctrl_decode : combinational opcode to datapath-control decode
// Revision: 1.0
// ============================================================================
module ctrl_decode
  import multicycle_ctrl_pkg::*;
#(
  parameter bit EN_OPIMM = 1'b1
) (
  input  logic [6:0] op,
  output dec_t       dec
);

  always_comb begin
    dec = '0;
    case (op)
      OPCODE_I: begin
        dec.alusrc   = 1'b1;
        dec.load     = 1'b1;
        dec.aluops   = OPCODE_I_ALU;
        dec.extnrops = EXTNR_I;
        dec.is_mem   = 1'b1;
        dec.legal    = 1'b1;
      end
      OPCODE_S: begin
        dec.alusrc   = 1'b1;
        dec.aluops   = OPCODE_S_ALU;
        dec.extnrops = EXTNR_S;
        dec.is_mem   = 1'b1;
        dec.is_store = 1'b1;
        dec.legal    = 1'b1;
      end
      OPCODE_R: begin
        dec.aluops = OPCODE_R_ALU;
        dec.legal  = 1'b1;
      end
      OPCODE_B: begin
        dec.aluops    = OPCODE_B_ALU;
        dec.extnrops  = EXTNR_B;
        dec.is_branch = 1'b1;
        dec.legal     = 1'b1;
      end
      OPCODE_OPIMM: begin
        // With OP-IMM disabled the opcode falls through as illegal.
        if (EN_OPIMM) begin
          dec.alusrc   = 1'b1;
          dec.aluops   = OPCODE_R_ALU;
          dec.extnrops = EXTNR_I;
          dec.legal    = 1'b1;
        end
      end
      default: dec = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : multi-cycle main control FSM with ready handshakes and traps
// Revision: 1.0
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int ALUOP_W  = 2,
  parameter int EXTNR_W  = 2,
  parameter int WAIT_MAX = 15,
  parameter bit EN_OPIMM = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_ready,
  input  logic [6:0]         instr,
  input  logic               dm_ready,
  input  logic               trap_ack,
  output logic               if_req,
  output logic               ir_write,
  output logic               pc_write,
  output logic               branch,
  output logic               alusrc,
  output logic               load,
  output logic [ALUOP_W-1:0] aluops,
  output logic [EXTNR_W-1:0] extnrops,
  output logic               memread,
  output logic               memwrite,
  output logic               regwrite,
  output logic               trap,
  output logic [1:0]         cause,
  output logic               busy
);

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_e     state_q, state_d;
  logic [6:0] op_q, op_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [1:0] cause_q, cause_d;
  dec_t       dec;

  ctrl_decode #(
    .EN_OPIMM (EN_OPIMM)
  ) u_decode (
    .op  (op_q),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      wait_cnt_q <= '0;
      cause_q    <= CAUSE_NONE;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wait_cnt_q <= wait_cnt_d;
      cause_q    <= cause_d;
    end
  end

  // wait_cnt only advances while parked in FETCH/MEM; any transition clears it.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cause_d    = cause_q;
    wait_cnt_d = '0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (if_ready) begin
          state_d = ST_DECODE;
          op_d    = instr;
        end else if (wait_cnt_q == WAIT_LIM) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_FETCH_TO;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_DECODE: begin
        if (dec.legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if (dec.is_branch)   state_d = ST_FETCH;
        else if (dec.is_mem) state_d = ST_MEM;
        else                 state_d = ST_WB;
      end
      ST_MEM: begin
        if (dm_ready) begin
          state_d = dec.is_store ? ST_FETCH : ST_WB;
        end else if (wait_cnt_q == WAIT_LIM) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_DATA_TO;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_WB: state_d = ST_FETCH;
      ST_TRAP: begin
        if (trap_ack) begin
          state_d = ST_FETCH;
          cause_d = CAUSE_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU controls stay up through MEM and WB so address/result remain stable.
  always_comb begin
    if_req   = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    branch   = 1'b0;
    alusrc   = 1'b0;
    load     = 1'b0;
    aluops   = '0;
    extnrops = '0;
    memread  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    trap     = 1'b0;
    cause    = cause_q;
    busy     = (state_q != ST_IDLE) && (state_q != ST_TRAP);
    case (state_q)
      ST_FETCH: begin
        if_req   = 1'b1;
        ir_write = if_ready;
        pc_write = if_ready;
      end
      ST_DECODE: extnrops = EXTNR_W'(dec.extnrops);
      ST_EXEC: begin
        alusrc   = dec.alusrc;
        aluops   = ALUOP_W'(dec.aluops);
        extnrops = EXTNR_W'(dec.extnrops);
        branch   = dec.is_branch;
      end
      ST_MEM: begin
        alusrc   = dec.alusrc;
        aluops   = ALUOP_W'(dec.aluops);
        extnrops = EXTNR_W'(dec.extnrops);
        memread  = dec.is_mem & ~dec.is_store;
        memwrite = dec.is_mem & dec.is_store;
      end
      ST_WB: begin
        alusrc   = dec.alusrc;
        aluops   = ALUOP_W'(dec.aluops);
        extnrops = EXTNR_W'(dec.extnrops);
        regwrite = 1'b1;
        load     = dec.load;
      end
      ST_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl : trace-model bench for multicycle_ctrl
// Revision: 1.0
// ============================================================================
module tb_multicycle_ctrl;

  localparam int WMAX = 3;

  typedef enum int {P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_TRAP} ph_e;
  typedef enum int {K_LW, K_SW, K_R, K_B, K_OPI, K_ILL} kind_e;

  typedef struct {
    ph_e        ph;
    kind_e      k;
    logic [6:0] op;
    bit         ifr;
    bit         dmr;
    bit         ack;
    logic [1:0] cause;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       if_ready = 1'b0, dm_ready = 1'b0, trap_ack = 1'b0;
  logic [6:0] instr = '0;

  logic       if_req_a, ir_write_a, pc_write_a, branch_a, alusrc_a, load_a;
  logic [1:0] aluops_a, extnrops_a, cause_a;
  logic       memread_a, memwrite_a, regwrite_a, trap_a, busy_a;
  logic       if_req_b, ir_write_b, pc_write_b, branch_b, alusrc_b, load_b;
  logic [1:0] aluops_b, extnrops_b, cause_b;
  logic       memread_b, memwrite_b, regwrite_b, trap_b, busy_b;

  int n_checks = 0;
  int n_err    = 0;
  cyc_t  q[$];
  kind_e cur_k;
  logic [6:0] cur_op;
  bit chk_b = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.ALUOP_W(2), .EXTNR_W(2), .WAIT_MAX(WMAX), .EN_OPIMM(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready), .instr(instr), .dm_ready(dm_ready),
    .trap_ack(trap_ack), .if_req(if_req_a), .ir_write(ir_write_a), .pc_write(pc_write_a),
    .branch(branch_a), .alusrc(alusrc_a), .load(load_a), .aluops(aluops_a),
    .extnrops(extnrops_a), .memread(memread_a), .memwrite(memwrite_a),
    .regwrite(regwrite_a), .trap(trap_a), .cause(cause_a), .busy(busy_a));

  multicycle_ctrl #(.ALUOP_W(2), .EXTNR_W(2), .WAIT_MAX(WMAX), .EN_OPIMM(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_ready(if_ready), .instr(instr), .dm_ready(dm_ready),
    .trap_ack(trap_ack), .if_req(if_req_b), .ir_write(ir_write_b), .pc_write(pc_write_b),
    .branch(branch_b), .alusrc(alusrc_b), .load(load_b), .aluops(aluops_b),
    .extnrops(extnrops_b), .memread(memread_b), .memwrite(memwrite_b),
    .regwrite(regwrite_b), .trap(trap_b), .cause(cause_b), .busy(busy_b));

  wire [16:0] obs_a = {if_req_a, ir_write_a, pc_write_a, branch_a, alusrc_a, load_a,
                       aluops_a, extnrops_a, memread_a, memwrite_a, regwrite_a,
                       trap_a, cause_a, busy_a};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] op_of(input kind_e k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_B:     return 7'b1100011;
      K_OPI:   return 7'b0010011;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit legal_op(input logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011};
  endfunction

  // Expected output bundle from the decode table and the phase of the cycle.
  function automatic logic [16:0] expect_out(input cyc_t c);
    logic       asrc = 1'b0;
    logic [1:0] aop = 2'b00, ext = 2'b00;
    bit f = (c.ph == P_FETCH), e = (c.ph == P_EXEC), m = (c.ph == P_MEM);
    bit w = (c.ph == P_WB), t = (c.ph == P_TRAP);
    bit alu_ph = e || m || w;
    bit ext_ph = alu_ph || (c.ph == P_DECODE);
    case (c.k)
      K_LW:  begin asrc = 1'b1; aop = 2'b00; ext = 2'b00; end
      K_SW:  begin asrc = 1'b1; aop = 2'b00; ext = 2'b01; end
      K_R:   begin asrc = 1'b0; aop = 2'b10; ext = 2'b00; end
      K_B:   begin asrc = 1'b0; aop = 2'b01; ext = 2'b10; end
      K_OPI: begin asrc = 1'b1; aop = 2'b10; ext = 2'b00; end
      default: ;
    endcase
    return {f, f && c.ifr, f && c.ifr, e && c.k == K_B, alu_ph && asrc,
            w && c.k == K_LW, alu_ph ? aop : 2'b00, ext_ph ? ext : 2'b00,
            m && c.k == K_LW, m && c.k == K_SW, w, t, t ? c.cause : 2'b00, !t};
  endfunction

  task automatic push(input ph_e ph, input bit ifr, input bit dmr, input bit ack,
                      input logic [1:0] cs);
    cyc_t c;
    c.ph = ph; c.k = cur_k; c.op = cur_op; c.ifr = ifr; c.dmr = dmr; c.ack = ack; c.cause = cs;
    q.push_back(c);
  endtask

  task automatic push_trap(input logic [1:0] cs, input int ackd);
    for (int j = 0; j < ackd; j++) push(P_TRAP, 1'b0, 1'b0, 1'b0, cs);
    push(P_TRAP, 1'b0, 1'b0, 1'b1, cs);
  endtask

  // One instruction's cycle trace; latencies beyond WMAX end in a timeout trap.
  task automatic plan(input kind_e k, input logic [6:0] op, input int flat, input int mlat,
                      input int ackd);
    cur_k = k; cur_op = op;
    for (int i = 0; i <= WMAX; i++) begin
      if (i == flat) begin push(P_FETCH, 1'b1, 1'b0, 1'b0, 2'b00); break; end
      push(P_FETCH, 1'b0, 1'b0, 1'b0, 2'b00);
      if (i == WMAX) begin push_trap(2'b10, ackd); return; end
    end
    push(P_DECODE, 1'b0, 1'b0, 1'b0, 2'b00);
    if (k == K_ILL) begin push_trap(2'b01, ackd); return; end
    push(P_EXEC, 1'b0, 1'b0, 1'b0, 2'b00);
    if (k == K_B) return;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= WMAX; i++) begin
        if (i == mlat) begin push(P_MEM, 1'b0, 1'b1, 1'b0, 2'b00); break; end
        push(P_MEM, 1'b0, 1'b0, 1'b0, 2'b00);
        if (i == WMAX) begin push_trap(2'b11, ackd); return; end
      end
      if (k == K_SW) return;
    end
    push(P_WB, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic run_queue(input int limit);
    int idx = 0;
    while (q.size() > 0 && idx < limit) begin
      cyc_t c = q.pop_front();
      @(posedge clk);
      #1;
      if_ready = (c.ph == P_FETCH) ? c.ifr : 1'($urandom);
      instr    = (c.ph == P_FETCH && c.ifr) ? c.op : 7'($urandom);
      dm_ready = (c.ph == P_MEM) ? c.dmr : 1'($urandom);
      trap_ack = (c.ph == P_TRAP) ? c.ack : 1'($urandom);
      @(negedge clk);
      chk($sformatf("cyc ph=%0d k=%0d", c.ph, c.k), 32'(obs_a), 32'(expect_out(c)));
      if (chk_b && idx == 1) chk("b_decode", {30'd0, busy_b, trap_b}, 32'h2);
      if (chk_b && idx == 2) chk("b_opimm_trap", {29'd0, trap_b, cause_b}, 32'h5);
      idx++;
    end
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk("reset_outputs", 32'(obs_a), 32'h0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", 32'(obs_a), 32'h0);
  endtask

  initial begin
    kind_e k;
    logic [6:0] op;
    do_reset(3);

    plan(K_LW, op_of(K_LW), 0, 2, 0);      run_queue(1000);
    plan(K_SW, op_of(K_SW), 1, 1, 0);      run_queue(1000);
    plan(K_B, op_of(K_B), 0, 0, 0);        run_queue(1000);
    plan(K_R, op_of(K_R), 2, 0, 0);        run_queue(1000);
    plan(K_ILL, 7'b1111111, 0, 0, 2);      run_queue(1000);
    plan(K_R, op_of(K_R), WMAX + 1, 0, 1); run_queue(1000);
    plan(K_OPI, op_of(K_OPI), WMAX, 0, 0); run_queue(1000);
    plan(K_LW, op_of(K_LW), 0, WMAX, 0);   run_queue(1000);
    plan(K_SW, op_of(K_SW), 0, WMAX + 1, 0); run_queue(1000);

    // Asynchronous reset while a load is parked in MEM.
    plan(K_LW, op_of(K_LW), 0, WMAX, 0);
    run_queue(4);
    q.delete();
    #2 rst_n = 1'b0;
    #1 chk("async_reset_drop", 32'(obs_a), 32'h0);
    do_reset(1);

    for (int n = 0; n < 40; n++) begin
      k = kind_e'($urandom_range(0, 5));
      op = op_of(k);
      if (k == K_ILL) begin
        op = 7'($urandom);
        while (legal_op(op)) op = 7'($urandom);
      end
      plan(k, op,
           ($urandom_range(0, 7) == 0) ? WMAX + 1 : int'($urandom_range(0, WMAX)),
           ($urandom_range(0, 7) == 0) ? WMAX + 1 : int'($urandom_range(0, WMAX)),
           int'($urandom_range(0, 2)));
      run_queue(1000);
    end

    // OP-IMM decoded on dut_a, trapped as illegal on dut_b.
    rst_n = 1'b0;
    do_reset(1);
    chk_b = 1'b1;
    plan(K_OPI, op_of(K_OPI), 0, 0, 0);
    run_queue(1000);
    chk_b = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
